dram_port_arbiter: RTL

- Shares the single external DRAM port between two requesters:
  - requester 0: the core-side memory controller.
  - requester 1: an auxiliary master (on-chip debugger loader or DMA).
- Round-robin arbitration; one outstanding DRAM transaction at a time.
- Captures the winning command and issues a one-cycle read/write enable pulse to DRAM.
- Waits for the DRAM ack, then returns ack and read data to the winner.
- Sits between the MCU top level and the external DRAM pins.

---
 rtl/dram_arb_pkg.sv | 15 +
 rtl/dram_arb_rr_pick.sv | 16 +
 rtl/dram_port_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-requester DRAM port arbiter.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam logic [31:0] TIMEOUT_RDATA          = 32'hDEAD_BEEF;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/dram_arb_rr_pick.sv
// Combinational 2-way round-robin selector: on a tie the requester that
// did not win last time is chosen.
module dram_arb_rr_pick
  import dram_arb_pkg::*;
(
  input  logic    valid0,
  input  logic    valid1,
  input  req_id_t last_grant,
  output req_id_t winner,
  output logic    any_valid
);

  assign any_valid = valid0 | valid1;
  assign winner    = (valid0 & valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one external DRAM port between the core memory controller (0) and an
// auxiliary master (1). Optional ack watchdog enabled by DRAM_ARB_TIMEOUT_EN.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
`ifdef DRAM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W/8-1:0]   req0_be,
  input  logic [DATA_W-1:0]     req0_wdata,
  output logic                  req0_ack,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W/8-1:0]   req1_be,
  input  logic [DATA_W-1:0]     req1_wdata,
  output logic                  req1_ack,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     dram_mem_addr,
  output logic                  dram_mem_read_en,
  output logic                  dram_mem_write_en,
  output logic [DATA_W/8-1:0]   dram_mem_byte_enable,
  output logic [DATA_W-1:0]     dram_mem_write_data,
  input  logic                  dram_ack,
  input  logic [DATA_W-1:0]     dram_mem_read_data,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  timeout_err
);

  localparam int BE_W = DATA_W / 8;

  // Handshake: reqN_valid is a level held until the one-cycle reqN_ack; the
  // requester drops valid in the ack cycle or it is taken as a new command.
  state_t  state;
  req_id_t last_grant;
  logic    cur_we;
  logic    timeout_hit;

  req_id_t            pick_id;
  logic               any_valid;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [BE_W-1:0]    win_be;
  logic [DATA_W-1:0]  win_wdata;

  dram_arb_rr_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .winner     (pick_id),
    .any_valid  (any_valid)
  );

  always_comb begin
    win_we    = req0_we;
    win_addr  = req0_addr;
    win_be    = req0_be;
    win_wdata = req0_wdata;
    if (pick_id) begin
      win_we    = req1_we;
      win_addr  = req1_addr;
      win_be    = req1_be;
      win_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state                <= IDLE;
      last_grant           <= 1'b1;
      cur_we               <= 1'b0;
      grant_id             <= 1'b0;
      busy                 <= 1'b0;
      req0_ack             <= 1'b0;
      req1_ack             <= 1'b0;
      rsp_rdata            <= '0;
      dram_mem_addr        <= '0;
      dram_mem_read_en     <= 1'b0;
      dram_mem_write_en    <= 1'b0;
      dram_mem_byte_enable <= '0;
      dram_mem_write_data  <= '0;
    end else begin
      dram_mem_read_en  <= 1'b0;
      dram_mem_write_en <= 1'b0;
      req0_ack          <= 1'b0;
      req1_ack          <= 1'b0;
      case (state)
        IDLE: begin
          // A dram_ack arriving here is stale and deliberately ignored.
          if (any_valid) begin
            grant_id             <= pick_id;
            cur_we               <= win_we;
            dram_mem_addr        <= win_addr;
            dram_mem_byte_enable <= win_we ? win_be : '1;
            dram_mem_write_data  <= win_wdata;
            dram_mem_read_en     <= ~win_we;
            dram_mem_write_en    <= win_we;
            busy                 <= 1'b1;
            state                <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (dram_ack || timeout_hit) begin
            req0_ack   <= ~grant_id;
            req1_ack   <= grant_id;
            rsp_rdata  <= timeout_hit ? DATA_W'(TIMEOUT_RDATA)
                                      : (cur_we ? '0 : dram_mem_read_data);
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_flag;

  assign timeout_hit = (state == WAIT) && !dram_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_flag;

  // Count starts at 0 in the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)
        timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
